// File: rtl/sram_port_arbiter.sv
// Arbitrates the single SRAM controller between the IF (fetch) and MEM (load/store) stages.
// One transaction at a time: IDLE grants, BUSY waits for sram_ready or times out, DONE acks.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_MEM_RUN = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    input  logic              sram_ready_i,
    output logic              freeze_mem_o,
    output logic              freeze_if_o,
    output logic              timeout_err_o
);

    localparam int unsigned RUN_W = 4;
    localparam int unsigned TMO_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_mem_q, owner_mem_d;
    logic                sram_req_q, sram_req_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                mem_ack_q, mem_ack_d;
    logic                if_ack_q, if_ack_d;
    logic                tmo_err_q, tmo_err_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                grant_if;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_mem_q  <= 1'b0;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            mem_rdata_q  <= '0;
            if_rdata_q   <= '0;
            mem_ack_q    <= 1'b0;
            if_ack_q     <= 1'b0;
            tmo_err_q    <= 1'b0;
            run_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_mem_q  <= owner_mem_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_ack_q    <= mem_ack_d;
            if_ack_q     <= if_ack_d;
            tmo_err_q    <= tmo_err_d;
            run_cnt_q    <= run_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        owner_mem_d  = owner_mem_q;
        sram_req_d   = sram_req_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_rdata_d   = if_rdata_q;
        mem_ack_d    = 1'b0;
        if_ack_d     = 1'b0;
        tmo_err_d    = tmo_err_q;
        run_cnt_d    = run_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        grant_if     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!if_req_i) begin
                    run_cnt_d = '0;
                end
                if (mem_req_i || if_req_i) begin
                    // IF wins only when MEM is idle or MEM has used up its run allowance
                    grant_if   = if_req_i && (!mem_req_i || (run_cnt_q == RUN_W'(MAX_MEM_RUN)));
                    state_d    = ST_BUSY;
                    sram_req_d = 1'b1;
                    tmo_cnt_d  = '0;
                    if (grant_if) begin
                        owner_mem_d  = 1'b0;
                        sram_we_d    = 1'b0;
                        sram_addr_d  = if_addr_i;
                        sram_wdata_d = '0;
                        run_cnt_d    = '0;
                    end else begin
                        owner_mem_d  = 1'b1;
                        sram_we_d    = mem_we_i;
                        sram_addr_d  = mem_addr_i;
                        sram_wdata_d = mem_wdata_i;
                        if (if_req_i && (run_cnt_q < RUN_W'(MAX_MEM_RUN))) begin
                            run_cnt_d = run_cnt_q + RUN_W'(1);
                        end
                    end
                end
            end
            ST_BUSY: begin
                if (sram_ready_i) begin
                    state_d    = ST_DONE;
                    sram_req_d = 1'b0;
                    if (owner_mem_q) begin
                        mem_rdata_d = sram_rdata_i;
                        mem_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = sram_rdata_i;
                        if_ack_d   = 1'b1;
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT)) begin
                    // Abort: owner still gets its ack, with an all-ones word
                    state_d    = ST_DONE;
                    sram_req_d = 1'b0;
                    tmo_err_d  = 1'b1;
                    if (owner_mem_q) begin
                        mem_rdata_d = {DATA_W{1'b1}};
                        mem_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = {DATA_W{1'b1}};
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                sram_req_d = 1'b0;
            end
        endcase
    end

    assign sram_req_o    = sram_req_q;
    assign sram_we_o     = sram_we_q;
    assign sram_addr_o   = sram_addr_q;
    assign sram_wdata_o  = sram_wdata_q;
    assign mem_rdata_o   = mem_rdata_q;
    assign if_rdata_o    = if_rdata_q;
    assign mem_ack_o     = mem_ack_q;
    assign if_ack_o      = if_ack_q;
    assign timeout_err_o = tmo_err_q;

    // Stall each stage while its request is outstanding
    assign freeze_mem_o  = mem_req_i & ~mem_ack_q;
    assign freeze_if_o   = if_req_i & ~if_ack_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: requester agents, an SRAM responder model and a
// scoreboard of expected grants/acks checked by a negedge monitor.
module tb_sram_port_arbiter;

    localparam logic [31:0] XOR_K   = 32'h2002_004A;
    localparam int          TMO_LAT = 65;

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          tmo;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mop_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        sram_req, sram_we, sram_ready;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;
    logic        freeze_mem, freeze_if, timeout_err;

    exp_t        sb[$];
    mop_t        mem_q[$];
    logic [31:0] if_q[$];
    exp_t        e_pop;
    mop_t        m_pop;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          resp_en  = 1'b1;
    int          resp_lat = 2;
    int          rise_cyc = 0;
    int          ready_cyc = 0;
    bit          req_prev = 1'b0;
    logic [31:0] last_mem_rdata = '0;
    logic [31:0] last_if_rdata  = '0;
    logic [31:0] got;

    sram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_MEM_RUN(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata), .sram_ready_i(sram_ready),
        .freeze_mem_o(freeze_mem), .freeze_if_o(freeze_if), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester agents: present the head op, advance once it is acked
    initial begin
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; if_req = 0; if_addr = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack && mem_q.size() > 0) m_pop = mem_q.pop_front();
            if (if_ack && if_q.size() > 0) if_q.delete(0);
            if (mem_q.size() > 0) begin
                mem_req = 1; mem_we = mem_q[0].we; mem_addr = mem_q[0].addr; mem_wdata = mem_q[0].wdata;
            end else begin
                mem_req = 0; mem_we = 0;
            end
            if (if_q.size() > 0) begin
                if_req = 1; if_addr = if_q[0];
            end else begin
                if_req = 0;
            end
        end
    end

    // SRAM controller model: ready resp_lat cycles after sram_req rises
    initial begin
        int cnt;
        cnt = 0; sram_ready = 0; sram_rdata = 0;
        forever begin
            @(posedge clk); #1;
            sram_ready = 0;
            if (sram_req && resp_en && !rst) begin
                if (cnt == resp_lat) begin
                    sram_ready = 1;
                    sram_rdata = sram_addr ^ XOR_K;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard monitor: grant contents on sram_req rise, owner/data/latency on ack
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                req_prev = 0;
            end else begin
                if (sram_req && !req_prev) begin
                    rise_cyc = cyc;
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL grant_unexpected: sram_req rose addr=%h, none expected", sram_addr);
                    end else if (sram_we !== sb[0].we || sram_addr !== sb[0].addr || sram_wdata !== sb[0].wdata) begin
                        n_fail++;
                        $display("FAIL grant: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                                 sram_we, sram_addr, sram_wdata, sb[0].we, sb[0].addr, sb[0].wdata);
                    end
                end
                if (sram_req && sram_ready) ready_cyc = cyc;
                if (mem_ack || if_ack) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL ack_unexpected: mem_ack=%b if_ack=%b, none expected", mem_ack, if_ack);
                    end else begin
                        e_pop = sb.pop_front();
                        if (mem_ack !== e_pop.is_mem || if_ack === e_pop.is_mem) begin
                            n_fail++;
                            $display("FAIL ack_owner: mem_ack=%b if_ack=%b, want mem_ack=%b", mem_ack, if_ack, e_pop.is_mem);
                        end
                        got = e_pop.is_mem ? mem_rdata : if_rdata;
                        n_checks++;
                        if (got !== e_pop.rdata) begin
                            n_fail++;
                            $display("FAIL ack_rdata: got %h, want %h", got, e_pop.rdata);
                        end
                        n_checks++;
                        if (e_pop.is_mem ? (if_rdata !== last_if_rdata) : (mem_rdata !== last_mem_rdata)) begin
                            n_fail++;
                            $display("FAIL other_rdata: mem=%h if=%h, want mem=%h if=%h",
                                     mem_rdata, if_rdata, e_pop.is_mem ? e_pop.rdata : last_mem_rdata,
                                     e_pop.is_mem ? last_if_rdata : e_pop.rdata);
                        end
                        n_checks++;
                        if (e_pop.tmo ? (cyc - rise_cyc != TMO_LAT) : (cyc != ready_cyc + 1)) begin
                            n_fail++;
                            $display("FAIL ack_latency: ack at %0d, sram_req rose %0d, ready %0d, tmo=%0b",
                                     cyc, rise_cyc, ready_cyc, e_pop.tmo);
                        end
                        if (e_pop.is_mem) last_mem_rdata = e_pop.rdata;
                        else              last_if_rdata  = e_pop.rdata;
                    end
                end
                req_prev = sram_req;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_drain(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && mem_q.size() == 0 && if_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_sram_req(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sram_req) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic push_if(input logic [31:0] a, input bit tmo);
        exp_t e;
        e = '{is_mem: 1'b0, we: 1'b0, addr: a, wdata: 32'h0,
              rdata: tmo ? 32'hFFFF_FFFF : (a ^ XOR_K), tmo: tmo};
        sb.push_back(e);
    endtask

    task automatic push_mem(input bit we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e = '{is_mem: 1'b1, we: we, addr: a, wdata: d, rdata: a ^ XOR_K, tmo: 1'b0};
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({sram_req, sram_we, mem_ack, if_ack, timeout_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b we=%b mack=%b iack=%b err=%b, want all 0",
                     sram_req, sram_we, mem_ack, if_ack, timeout_err);
        end
        n_checks++;
        if (sram_addr !== 32'h0 || sram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_sram_bus: addr=%h wdata=%h, want 0", sram_addr, sram_wdata);
        end
        n_checks++;
        if (mem_rdata !== 32'h0 || if_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: mem=%h if=%h, want 0", mem_rdata, if_rdata);
        end
        n_checks++;
        if (freeze_mem !== 1'b0 || freeze_if !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_freeze: mem=%b if=%b, want 0", freeze_mem, freeze_if);
        end
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (sram_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_req: cycle %0d sram_req=%b, want 0", i, sram_req);
            end
        end
    endtask

    task automatic test_if_read();
        bit ok;
        resp_lat = 2;
        @(negedge clk);
        push_if(32'h40, 1'b0);
        if_q.push_back(32'h40);
        wait_sram_req(10, ok);
        n_checks++;
        if (!ok || freeze_if !== 1'b1) begin
            n_fail++;
            $display("FAIL if_pending: sram_req seen=%b freeze_if=%b, want 1/1", ok, freeze_if);
        end
        wait_drain(30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL if_drain: %0d acks outstanding, want 0", sb.size());
        end
        n_checks++;
        if (if_rdata !== 32'h2002_000A || freeze_if !== 1'b0) begin
            n_fail++;
            $display("FAIL if_after_ack: if_rdata=%h freeze_if=%b, want 2002000a/0", if_rdata, freeze_if);
        end
    endtask

    task automatic test_mem_write_and_if();
        bit   ok;
        mop_t m;
        resp_lat = 0;
        @(negedge clk);
        push_mem(1'b1, 32'h400, 32'hDEAD_BEEF);
        push_if(32'h44, 1'b0);
        m = '{we: 1'b1, addr: 32'h400, wdata: 32'hDEAD_BEEF};
        mem_q.push_back(m);
        if_q.push_back(32'h44);
        wait_drain(40, ok);
        repeat (5) @(negedge clk);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL mw_if_drain: %0d acks outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_mem_run_limit();
        bit   ok;
        mop_t m;
        resp_lat = 1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_mem(i[0], 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        push_if(32'h100, 1'b0);
        for (int i = 4; i < 6; i++) push_mem(i[0], 32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        push_if(32'h104, 1'b0);
        for (int i = 0; i < 6; i++) begin
            m = '{we: i[0], addr: 32'h1000 + 32'(4 * i), wdata: 32'hA000_0000 + 32'(i)};
            mem_q.push_back(m);
        end
        if_q.push_back(32'h100);
        if_q.push_back(32'h104);
        wait_drain(100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL run_drain: %0d acks outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_ready_at_limit();
        bit ok;
        resp_lat = 64;
        @(negedge clk);
        push_if(32'h60, 1'b0);
        if_q.push_back(32'h60);
        wait_drain(120, ok);
        n_checks++;
        if (!ok || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_at_limit: drained=%b timeout_err=%b, want 1/0", ok, timeout_err);
        end
    endtask

    task automatic test_timeout();
        bit   ok;
        mop_t m;
        resp_en = 0;
        @(negedge clk);
        push_if(32'h80, 1'b1);
        if_q.push_back(32'h80);
        wait_drain(120, ok);
        n_checks++;
        if (!ok || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: drained=%b timeout_err=%b, want 1/1", ok, timeout_err);
        end
        resp_en = 1;
        resp_lat = 1;
        push_mem(1'b0, 32'h84, 32'h0);
        m = '{we: 1'b0, addr: 32'h84, wdata: 32'h0};
        mem_q.push_back(m);
        wait_drain(30, ok);
        n_checks++;
        if (!ok || timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: drained=%b timeout_err=%b, want 1/1", ok, timeout_err);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        last_mem_rdata = '0;
        last_if_rdata  = '0;
        @(negedge clk);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: timeout_err=%b after rst, want 0", timeout_err);
        end
    endtask

    task automatic test_reset_in_busy();
        bit   ok;
        mop_t m;
        resp_en = 0;
        @(negedge clk);
        push_if(32'hC0, 1'b0);
        if_q.push_back(32'hC0);
        wait_sram_req(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rib_grant: sram_req never rose, want 1");
        end
        rst = 1;
        if_q.delete();
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (sram_req !== 1'b0 || mem_ack !== 1'b0 || if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rib_abandon: sram_req=%b mem_ack=%b if_ack=%b, want 0/0/0", sram_req, mem_ack, if_ack);
        end
        @(posedge clk); #1;
        rst = 0;
        resp_en = 1;
        resp_lat = 2;
        last_mem_rdata = '0;
        last_if_rdata  = '0;
        repeat (6) @(negedge clk);
        push_mem(1'b0, 32'hC4, 32'h0);
        m = '{we: 1'b0, addr: 32'hC4, wdata: 32'h0};
        mem_q.push_back(m);
        wait_drain(30, ok);
        n_checks++;
        if (!ok || mem_rdata !== (32'hC4 ^ XOR_K)) begin
            n_fail++;
            $display("FAIL rib_resume: drained=%b mem_rdata=%h, want 1/%h", ok, mem_rdata, 32'hC4 ^ XOR_K);
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write_and_if();
        test_mem_run_limit();
        test_ready_at_limit();
        test_timeout();
        test_reset_in_busy();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
